// File: rtl/jelly2_img_to_axi4s_fifo_if.sv
// AXI4-Stream video bundle leaving the image-to-AXI4-Stream FIFO.
// tuser[0] marks start of frame, tlast marks end of line.
interface jelly2_img_to_axi4s_fifo_if #(
  parameter int TUSER_WIDTH = 1,
  parameter int TDATA_WIDTH = 8
);
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tuser,
    output tlast,
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tuser,
    input  tlast,
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/jelly2_img_to_axi4s_fifo.sv
// Image bus to AXI4-Stream video with a back-pressure FIFO.
// Overflow drops the rest of a frame until the next start of frame.
module jelly2_img_to_axi4s_fifo #(
  parameter int TUSER_WIDTH    = 1,
  parameter int TDATA_WIDTH    = 8,
  parameter int FIFO_PTR_WIDTH = 5,
  parameter bit WITH_VALID     = 1'b1,
  localparam int USER_WIDTH =
    (TUSER_WIDTH > 1) ? TUSER_WIDTH - 1 : 1
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    s_img_cke,
  input  logic                    s_img_row_first,
  input  logic                    s_img_row_last,
  input  logic                    s_img_col_first,
  input  logic                    s_img_col_last,
  input  logic                    s_img_de,
  input  logic [USER_WIDTH-1:0]   s_img_user,
  input  logic [TDATA_WIDTH-1:0]  s_img_data,
  input  logic                    s_img_valid,

  jelly2_img_to_axi4s_fifo_if.master m_axi4s,

  input  logic                    clear_status,
  output logic                    overflow,
  output logic [15:0]             drop_count,
  output logic [FIFO_PTR_WIDTH:0] fifo_free_count
);

  localparam int SW = TUSER_WIDTH + 1 + TDATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam logic [FIFO_PTR_WIDTH:0] DEPTH_V =
    {1'b1, {FIFO_PTR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    WAIT_SOF,
    PASS,
    DROP
  } state_t;

  state_t state;

  logic [SW-1:0]             mem [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
  logic [FIFO_PTR_WIDTH:0]   count;
  logic [FIFO_PTR_WIDTH:0]   count_next;

  logic                   beat;
  logic                   sof;
  logic                   full;
  logic                   wr_en;
  logic                   rd_en;
  logic                   drop_ev;
  logic [TUSER_WIDTH-1:0] wr_tuser;
  logic [SW-1:0]          wr_word;
  logic [SW-1:0]          rd_word;

  assign beat = s_img_cke && s_img_de
             && (s_img_valid || !WITH_VALID);
  assign sof  = s_img_row_first && s_img_col_first;
  assign full = (count == DEPTH_V);

  if (TUSER_WIDTH > 1) begin : g_user
    logic unused_in;
    assign unused_in = s_img_row_last;
    assign wr_tuser  = {s_img_user, sof};
  end else begin : g_nouser
    logic unused_in;
    assign unused_in = s_img_row_last ^ (^s_img_user);
    assign wr_tuser  = sof;
  end

  assign wr_word = {wr_tuser, s_img_col_last, s_img_data};

  always_comb begin
    wr_en   = 1'b0;
    drop_ev = 1'b0;
    if (beat) begin
      unique case (state)
        WAIT_SOF: wr_en = sof && !full;
        PASS: begin
          wr_en   = !full;
          drop_ev = full;
        end
        DROP: begin
          wr_en   = sof && !full;
          drop_ev = sof && full;
        end
        default: ;
      endcase
    end
  end

  assign rd_en = m_axi4s.tvalid && m_axi4s.tready;

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) count_next = count + 1'b1;
    if (!wr_en && rd_en) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      m_axi4s.tvalid  <= 1'b0;
      fifo_free_count <= DEPTH_V;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count           <= count_next;
      m_axi4s.tvalid  <= (count_next != '0);
      fifo_free_count <= DEPTH_V - count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SOF;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en) state <= PASS;
      else if (drop_ev) state <= DROP;

      if (drop_ev) begin
        overflow <= 1'b1;
        if (clear_status) drop_count <= 16'd1;
        else if (drop_count != 16'hffff)
          drop_count <= drop_count + 16'd1;
      end else if (clear_status) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  // Idle outputs read as zero; a pending word is held from storage.
  assign rd_word = m_axi4s.tvalid ? mem[rd_ptr] : '0;

  assign m_axi4s.tuser =
    rd_word[SW-1 -: TUSER_WIDTH];
  assign m_axi4s.tlast = rd_word[TDATA_WIDTH];
  assign m_axi4s.tdata = rd_word[TDATA_WIDTH-1:0];

endmodule

// File: tb/tb_jelly2_img_to_axi4s_fifo.sv
// Randomized bench for jelly2_img_to_axi4s_fifo against a queue model.
// The queue holds exactly the beats the FIFO should be storing.
module tb_jelly2_img_to_axi4s_fifo;

  localparam int TU    = 3;
  localparam int TD    = 8;
  localparam int PW    = 5;
  localparam int DEPTH = 32;
  localparam int UW    = 2;
  localparam int WW    = TU + 1 + TD;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cke, rf, rl, cf, cl, de, valid, clear;
  logic [UW-1:0] user;
  logic [TD-1:0] data;
  logic          ovf;
  logic [15:0]   dcnt;
  logic [PW:0]   freec;

  jelly2_img_to_axi4s_fifo_if #(
    .TUSER_WIDTH(TU),
    .TDATA_WIDTH(TD)
  ) axi ();

  jelly2_img_to_axi4s_fifo #(
    .TUSER_WIDTH   (TU),
    .TDATA_WIDTH   (TD),
    .FIFO_PTR_WIDTH(PW),
    .WITH_VALID    (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_img_cke      (cke),
    .s_img_row_first(rf),
    .s_img_row_last (rl),
    .s_img_col_first(cf),
    .s_img_col_last (cl),
    .s_img_de       (de),
    .s_img_user     (user),
    .s_img_data     (data),
    .s_img_valid    (valid),
    .m_axi4s        (axi),
    .clear_status   (clear),
    .overflow       (ovf),
    .drop_count     (dcnt),
    .fifo_free_count(freec)
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] q[$];
  int            mode;
  logic          m_ovf;
  logic [15:0]   m_drop;
  int            rdy_mode;
  int            clr_at;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic tick();
    logic b, s, f, rd, ev;
    if (rdy_mode == 2) axi.tready = 1'($urandom_range(0, 1));
    else axi.tready = (rdy_mode == 1);
    b = cke && de && valid;
    s = rf && cf;
    f = (q.size() == DEPTH);
    chk("tvalid", 32'(axi.tvalid), 32'(q.size() != 0));
    chk("free", 32'(freec), 32'(DEPTH - q.size()));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("drop_count", 32'(dcnt), 32'(m_drop));
    if (q.size() != 0)
      chk("beat", 32'({axi.tuser, axi.tlast, axi.tdata}),
          32'(q[0]));
    rd = axi.tvalid && axi.tready;
    if (rd && q.size() != 0) void'(q.pop_front());
    ev = 1'b0;
    if (b) begin
      if (mode == 0) begin
        if (s && !f) begin
          q.push_back({user, s, cl, data}); mode = 1;
        end
      end else if (mode == 1) begin
        if (!f) q.push_back({user, s, cl, data});
        else begin mode = 2; ev = 1'b1; end
      end else if (s) begin
        if (!f) begin
          q.push_back({user, s, cl, data}); mode = 1;
        end else ev = 1'b1;
      end
    end
    if (ev) begin
      m_ovf = 1'b1;
      if (clear) m_drop = 16'd1;
      else if (m_drop != 16'hffff) m_drop = m_drop + 16'd1;
    end else if (clear) begin
      m_ovf = 1'b0; m_drop = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    cke = 1'b1; de = 1'b0; valid = 1'b1; clear = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cke = 1'b0; de = 1'b0; valid = 1'b0; clear = 1'b0;
    rf = 1'b0; rl = 1'b0; cf = 1'b0; cl = 1'b0;
    user = '0; data = '0; axi.tready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); mode = 0; m_ovf = 1'b0; m_drop = '0;
    chk("rst_tvalid", 32'(axi.tvalid), 32'd0);
    chk("rst_tdata", 32'(axi.tdata), 32'd0);
    chk("rst_tuser", 32'(axi.tuser), 32'd0);
    chk("rst_tlast", 32'(axi.tlast), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(dcnt), 32'd0);
    chk("rst_free", 32'(freec), 32'(DEPTH));
  endtask

  task automatic send_frame(int w, int h, int r0, int pbub);
    int p = 0;
    for (int r = r0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        rf = (r == 0); rl = (r == h - 1);
        cf = (c == 0); cl = (c == w - 1);
        while ($urandom_range(0, 99) < pbub) begin
          int k = $urandom_range(0, 2);
          cke = (k != 0); valid = (k != 1); de = (k != 2);
          data = 8'($urandom); user = 2'($urandom);
          tick();
        end
        cke = 1'b1; valid = 1'b1; de = 1'b1;
        data = 8'($urandom); user = 2'($urandom);
        clear = (p == clr_at);
        tick();
        clear = 1'b0;
        p++;
      end
    end
    de = 1'b0;
  endtask

  initial begin
    rdy_mode = 1;
    clr_at   = -1;
    do_reset();

    // Basic 4x3 frame, free-flowing sink.
    send_frame(4, 3, 0, 0);
    idle(6);
    chk("basic_ovf", 32'(ovf), 32'd0);

    // Start mid-frame: rows without SOF are discarded.
    do_reset();
    send_frame(4, 3, 1, 0);
    idle(2);
    chk("mid_free", 32'(freec), 32'(DEPTH));
    send_frame(4, 3, 0, 0);
    idle(6);
    chk("mid_drop", 32'(dcnt), 32'd0);

    // Back-pressure: 40-pixel line into a 32-deep FIFO.
    do_reset();
    rdy_mode = 0;
    send_frame(40, 2, 0, 0);
    idle(2);
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_drop", 32'(dcnt), 32'd1);
    chk("bp_free", 32'(freec), 32'd0);
    send_frame(4, 2, 0, 0);
    idle(1);
    chk("bp_drop2", 32'(dcnt), 32'd2);
    rdy_mode = 1;
    idle(40);
    send_frame(4, 2, 0, 0);
    idle(10);

    // clear_status coincident with the drop event.
    do_reset();
    rdy_mode = 0;
    clr_at = 32;
    send_frame(40, 1, 0, 0);
    clr_at = -1;
    idle(1);
    chk("clr_ev_ovf", 32'(ovf), 32'd1);
    chk("clr_ev_drop", 32'(dcnt), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drop", 32'(dcnt), 32'd0);

    // Reset mid-frame with data pending.
    rdy_mode = 1;
    idle(40);
    rdy_mode = 0;
    send_frame(6, 2, 0, 0);
    do_reset();
    send_frame(6, 2, 1, 0);
    chk("rst_mid_free", 32'(freec), 32'(DEPTH));

    // de=1 with valid=0 never writes.
    rdy_mode = 1;
    rf = 1'b1; cf = 1'b1;
    cke = 1'b1; de = 1'b1; valid = 1'b0;
    repeat (5) tick();
    chk("novalid_free", 32'(freec), 32'(DEPTH));

    // Random frames, bubbles and random back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      send_frame($urandom_range(2, 12), $urandom_range(1, 4),
                 ($urandom_range(0, 5) == 0) ? 1 : 0, 20);
      idle($urandom_range(0, 4));
    end

    rdy_mode = 1;
    cke = 1'b1; de = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("drain", 32'(q.size()), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
